// File: rtl/prf_pkg.sv
// Shared types and defaults for the multi-ported physical register file.
// Bypass selection helper picks the highest-indexed matching write port.
package prf_pkg;

  localparam int PRF_PHYS_REGS = 64;
  localparam int PRF_XLEN      = 32;
  localparam int PRF_PW        = $clog2(PRF_PHYS_REGS);
  localparam int MAX_WR        = 8;

  typedef logic [PRF_PW-1:0]   preg_t;
  typedef logic [PRF_XLEN-1:0] xlen_t;

  function automatic logic [2:0] bypass_sel(input logic [MAX_WR-1:0] hit);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (hit[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/prf_ready_table.sv
// Ready-bit scoreboard: flush > alloc > write-back precedence, register 0 always ready.
module prf_ready_table
  import prf_pkg::*;
#(
  parameter int PHYS_REGS = PRF_PHYS_REGS,
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 1,
  parameter int PW        = $clog2(PHYS_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_RD*PW-1:0]    rd_tag,
  output logic [NUM_RD-1:0]       rd_ready,
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*PW-1:0]    wr_tag,
  input  logic [NUM_ALLOC-1:0]    alloc_en,
  input  logic [NUM_ALLOC*PW-1:0] alloc_tag,
  input  logic                    flush
);

  logic [PHYS_REGS-1:0] ready_r;
  logic [PHYS_REGS-1:0] set_s;
  logic [PHYS_REGS-1:0] clr_s;
  logic [PHYS_REGS-1:0] ready_nxt_s;

  // Decode write-back sets and allocate clears, then apply precedence.
  always_comb begin
    set_s = {PHYS_REGS{1'b0}};
    clr_s = {PHYS_REGS{1'b0}};
    for (int r = 1; r < PHYS_REGS; r++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        set_s[r] = set_s[r] | (wr_en[w] & (wr_tag[w*PW +: PW] == PW'(r)));
      end
      for (int a = 0; a < NUM_ALLOC; a++) begin
        clr_s[r] = clr_s[r] | (alloc_en[a] & (alloc_tag[a*PW +: PW] == PW'(r)));
      end
    end
    ready_nxt_s = flush ? {PHYS_REGS{1'b1}} : (((ready_r | set_s) & ~clr_s) | {{(PHYS_REGS-1){1'b0}}, 1'b1});
  end

  // Ready vector state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= {PHYS_REGS{1'b1}};
    end else begin
      ready_r <= ready_nxt_s;
    end
  end

  // Per-port ready lookup.
  always_comb begin
    rd_ready = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      rd_ready[k] = ready_r[rd_tag[k*PW +: PW]] | (rd_tag[k*PW +: PW] == {PW{1'b0}});
    end
  end

endmodule

// File: rtl/prf_mp.sv
// Multi-ported physical register file with integrated ready scoreboard.
// Optional same-cycle write-back bypass enabled by defining PRF_BYPASS_EN.
module prf_mp
  import prf_pkg::*;
#(
  parameter int PHYS_REGS = PRF_PHYS_REGS,
  parameter int XLEN      = PRF_XLEN,
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 1,
  parameter int PW        = $clog2(PHYS_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_RD*PW-1:0]    rd_tag,
  output logic [NUM_RD*XLEN-1:0]  rd_data,
  output logic [NUM_RD-1:0]       rd_ready,
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*PW-1:0]    wr_tag,
  input  logic [NUM_WR*XLEN-1:0]  wr_data,
  input  logic [NUM_ALLOC-1:0]    alloc_en,
  input  logic [NUM_ALLOC*PW-1:0] alloc_tag,
  input  logic                    flush,
  output logic                    wr_conflict
);

  logic [XLEN-1:0]   mem_r [PHYS_REGS];
  logic              wr_conflict_r;
  logic              conflict_s;
  logic [NUM_RD-1:0] tbl_ready_s;
  logic [PW-1:0]     tag_s;
  logic [XLEN-1:0]   data_s;
  logic              rdy_s;
`ifdef PRF_BYPASS_EN
  logic [MAX_WR-1:0] hit_s;
  logic              ahit_s;
`endif

  prf_ready_table #(
    .PHYS_REGS (PHYS_REGS),
    .NUM_RD    (NUM_RD),
    .NUM_WR    (NUM_WR),
    .NUM_ALLOC (NUM_ALLOC),
    .PW        (PW)
  ) u_ready (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_tag    (rd_tag),
    .rd_ready  (tbl_ready_s),
    .wr_en     (wr_en),
    .wr_tag    (wr_tag),
    .alloc_en  (alloc_en),
    .alloc_tag (alloc_tag),
    .flush     (flush)
  );

  // Data array; later ports overwrite earlier ones so the highest port wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        mem_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_tag[w*PW +: PW] != {PW{1'b0}})) begin
          mem_r[wr_tag[w*PW +: PW]] <= wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Detect two enabled write ports targeting the same non-zero tag.
  always_comb begin
    conflict_s = 1'b0;
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        conflict_s = conflict_s | (wr_en[a] & wr_en[b] &
                     (wr_tag[a*PW +: PW] == wr_tag[b*PW +: PW]) &
                     (wr_tag[a*PW +: PW] != {PW{1'b0}}));
      end
    end
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_conflict_r <= 1'b0;
    end else begin
      wr_conflict_r <= wr_conflict_r | conflict_s;
    end
  end

  assign wr_conflict = wr_conflict_r;

  // Combinational read ports with optional write-back bypass.
  always_comb begin
    rd_data  = {(NUM_RD*XLEN){1'b0}};
    rd_ready = {NUM_RD{1'b0}};
    tag_s    = {PW{1'b0}};
    data_s   = {XLEN{1'b0}};
    rdy_s    = 1'b0;
`ifdef PRF_BYPASS_EN
    hit_s    = {MAX_WR{1'b0}};
    ahit_s   = 1'b0;
`endif
    for (int k = 0; k < NUM_RD; k++) begin
      tag_s  = rd_tag[k*PW +: PW];
      data_s = (tag_s == {PW{1'b0}}) ? {XLEN{1'b0}} : mem_r[tag_s];
      rdy_s  = tbl_ready_s[k];
`ifdef PRF_BYPASS_EN
      hit_s  = {MAX_WR{1'b0}};
      ahit_s = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        hit_s[w] = wr_en[w] & (wr_tag[w*PW +: PW] == tag_s) & (tag_s != {PW{1'b0}});
      end
      for (int a = 0; a < NUM_ALLOC; a++) begin
        ahit_s = ahit_s | (alloc_en[a] & (alloc_tag[a*PW +: PW] == tag_s));
      end
      if (|hit_s) begin
        data_s = wr_data[int'(bypass_sel(hit_s))*XLEN +: XLEN];
        rdy_s  = rdy_s | ~ahit_s;
      end else begin
        data_s = data_s;
      end
`endif
      rd_data[k*XLEN +: XLEN] = data_s;
      rd_ready[k]             = rdy_s;
    end
  end

endmodule

// File: tb/tb_prf_mp.sv
// Self-checking bench for prf_mp: directed literal checks plus randomized traffic vs a reference model.
module tb_prf_mp;

  localparam int PW = 6;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int NA = 1;
  localparam int XL = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR*PW-1:0]  rd_tag = '0;
  logic [NR*XL-1:0]  rd_data;
  logic [NR-1:0]     rd_ready;
  logic [NW-1:0]     wr_en = '0;
  logic [NW*PW-1:0]  wr_tag = '0;
  logic [NW*XL-1:0]  wr_data = '0;
  logic [NA-1:0]     alloc_en = '0;
  logic [NA*PW-1:0]  alloc_tag = '0;
  logic              flush = 1'b0;
  logic              wr_conflict;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  logic [XL-1:0] m_data [64];
  logic [63:0]   m_ready;
  logic          m_conflict;

  prf_mp dut (
    .clk(clk), .rst_n(rst_n), .rd_tag(rd_tag), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_tag(wr_tag), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_tag(alloc_tag), .flush(flush), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ready_next(input logic [63:0] cur);
    logic [63:0] r;
    r = cur;
    for (int w = 0; w < NW; w++)
      if (wr_en[w] && wr_tag[w*PW +: PW] != 0) r[wr_tag[w*PW +: PW]] = 1'b1;
    for (int a = 0; a < NA; a++)
      if (alloc_en[a] && alloc_tag[a*PW +: PW] != 0) r[alloc_tag[a*PW +: PW]] = 1'b0;
    if (flush) r = {64{1'b1}};
    return r;
  endfunction

  function automatic logic conflict_now();
    int cnt [64];
    logic c;
    c = 1'b0;
    for (int i = 0; i < 64; i++) cnt[i] = 0;
    for (int w = 0; w < NW; w++)
      if (wr_en[w] && wr_tag[w*PW +: PW] != 0) cnt[wr_tag[w*PW +: PW]]++;
    for (int i = 0; i < 64; i++) if (cnt[i] > 1) c = 1'b1;
    return c;
  endfunction

  // Reference model state update.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m_data[i] <= '0;
      m_ready    <= {64{1'b1}};
      m_conflict <= 1'b0;
    end else begin
      for (int w = 0; w < NW; w++)
        if (wr_en[w] && wr_tag[w*PW +: PW] != 0) m_data[wr_tag[w*PW +: PW]] <= wr_data[w*XL +: XL];
      m_ready    <= ready_next(m_ready);
      m_conflict <= m_conflict | conflict_now();
    end
  end

  function automatic void exp_port(input int k, output logic [XL-1:0] d, output logic r);
    logic [PW-1:0] t;
    t = rd_tag[k*PW +: PW];
    d = (t == 0) ? '0 : m_data[t];
    r = (t == 0) ? 1'b1 : m_ready[t];
`ifdef PRF_BYPASS_EN
    begin
      logic hit, ahit;
      hit = 1'b0;
      ahit = 1'b0;
      for (int w = 0; w < NW; w++)
        if (wr_en[w] && t != 0 && wr_tag[w*PW +: PW] == t) begin
          hit = 1'b1;
          d = wr_data[w*XL +: XL];
        end
      for (int a = 0; a < NA; a++)
        if (alloc_en[a] && alloc_tag[a*PW +: PW] == t) ahit = 1'b1;
      if (hit && !ahit) r = 1'b1;
    end
`endif
  endfunction

  task automatic check(input string name, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en && rst_n === 1'b1) begin
      for (int k = 0; k < NR; k++) begin
        logic [XL-1:0] d;
        logic r;
        exp_port(k, d, r);
        check($sformatf("cmp_data%0d", k), rd_data[k*XL +: XL], d);
        check($sformatf("cmp_ready%0d", k), {31'd0, rd_ready[k]}, {31'd0, r});
      end
      check("cmp_conflict", {31'd0, wr_conflict}, {31'd0, m_conflict});
    end
  end

  task automatic idle();
    wr_en = '0; wr_tag = '0; wr_data = '0; alloc_en = '0; alloc_tag = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input int t);
    rd_tag[k*PW +: PW] = PW'(t);
  endtask

  task automatic wr(input int p, input int t, input logic [XL-1:0] v);
    wr_en[p] = 1'b1;
    wr_tag[p*PW +: PW] = PW'(t);
    wr_data[p*XL +: XL] = v;
  endtask

  task automatic alloc(input int t);
    alloc_en[0] = 1'b1;
    alloc_tag[PW-1:0] = PW'(t);
  endtask

  task automatic check_all_reset(input string name);
    for (int k = 0; k < NR; k++) begin
      check({name, "_data"}, rd_data[k*XL +: XL], 32'd0);
      check({name, "_ready"}, {31'd0, rd_ready[k]}, 32'd1);
    end
  endtask

  initial begin
    idle();
    #12 rst_n = 1'b1;
    #1;
    cmp_en = 1'b1;
    check_all_reset("reset_initial");
    check("reset_conflict", {31'd0, wr_conflict}, 32'd0);

    // write/read tag 12
    tick();
    wr(0, 12, 32'hDEADBEEF);
    set_rd(0, 12);
`ifdef PRF_BYPASS_EN
    #1;
    check("wr12_bypass_data", rd_data[31:0], 32'hDEADBEEF);
`endif
    tick();
    idle();
    #1;
    check("wr12_data", rd_data[31:0], 32'hDEADBEEF);
    check("wr12_ready", {31'd0, rd_ready[0]}, 32'd1);

    // tag 0 writes and allocs are discarded
    wr(0, 0, 32'h1234);
    set_rd(1, 0);
    tick();
    idle();
    #1;
    check("tag0_data", rd_data[63:32], 32'd0);
    check("tag0_ready", {31'd0, rd_ready[1]}, 32'd1);
    alloc(0);
    tick();
    idle();
    #1;
    check("tag0_alloc_ready", {31'd0, rd_ready[1]}, 32'd1);

    // alloc and write same tag: ready cleared, data written
    alloc(20);
    wr(0, 20, 32'h55);
    set_rd(0, 20);
    tick();
    idle();
    #1;
    check("alloc20_ready", {31'd0, rd_ready[0]}, 32'd0);
    check("alloc20_data", rd_data[31:0], 32'h55);
    wr(1, 20, 32'h77);
    tick();
    idle();
    #1;
    check("wb20_ready", {31'd0, rd_ready[0]}, 32'd1);
    check("wb20_data", rd_data[31:0], 32'h77);

    // flush after allocs over three cycles
    wr(0, 3, 32'h333); wr(1, 4, 32'h444);
    tick(); idle();
    wr(0, 5, 32'h555);
    tick(); idle();
    alloc(3); tick(); idle();
    alloc(4); tick(); idle();
    alloc(5); tick(); idle();
    set_rd(0, 3); set_rd(1, 4); set_rd(2, 5);
    #1;
    check("pre_flush_r3", {31'd0, rd_ready[0]}, 32'd0);
    check("pre_flush_r5", {31'd0, rd_ready[2]}, 32'd0);
    flush = 1'b1;
    tick();
    idle();
    #1;
    check("flush_r3", {31'd0, rd_ready[0]}, 32'd1);
    check("flush_r4", {31'd0, rd_ready[1]}, 32'd1);
    check("flush_r5", {31'd0, rd_ready[2]}, 32'd1);
    check("flush_d4", rd_data[63:32], 32'h444);
    check("flush_d5", rd_data[95:64], 32'h555);

    // same-tag conflict
    check("pre_conflict", {31'd0, wr_conflict}, 32'd0);
    wr(0, 7, 32'h11); wr(1, 7, 32'h22);
    set_rd(3, 7);
    tick();
    idle();
    #1;
    check("conflict_data", rd_data[127:96], 32'h22);
    check("conflict_flag", {31'd0, wr_conflict}, 32'd1);
    tick();
    check("conflict_held", {31'd0, wr_conflict}, 32'd1);

    // asynchronous reset after writes to 5 and 9
    wr(0, 5, 32'hAAAA0005); wr(1, 9, 32'hBBBB0009);
    tick();
    idle();
    set_rd(0, 5); set_rd(1, 9); set_rd(2, 5); set_rd(3, 9);
    #1;
    check("pre_reset_d9", rd_data[63:32], 32'hBBBB0009);
    rst_n = 1'b0;
    #1;
    check_all_reset("reset_async");
    check("reset_async_conflict", {31'd0, wr_conflict}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check_all_reset("reset_release");

    // randomized traffic checked every cycle by the compare process
    for (int c = 0; c < 600; c++) begin
      tick();
      wr_en = NW'($urandom);
      for (int w = 0; w < NW; w++) begin
        wr_tag[w*PW +: PW] = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, 63)) : PW'($urandom_range(0, 15));
        wr_data[w*XL +: XL] = $urandom;
      end
      alloc_en[0] = ($urandom_range(0, 2) == 0);
      alloc_tag[PW-1:0] = PW'($urandom_range(0, 15));
      flush = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < NR; k++) rd_tag[k*PW +: PW] = PW'($urandom_range(0, 15));
      if (c == 300) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    end
    tick();
    idle();
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
